// File: rtl/rr_grant_arbiter_pkg.sv
// Shared arbiter types and helpers: FSM state type, count-width and one-hot-to-index functions.
package rr_grant_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  // Widest requester vector any arbiter using these helpers may have.
  localparam int unsigned MaxReq = 32;

  // Bits needed to hold a population count of 0..n.
  function automatic int unsigned count_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  // Index of the set bit of a one-hot (or zero) vector; zero input yields 0.
  function automatic int unsigned onehot_to_idx(input logic [MaxReq-1:0] onehot);
    int unsigned idx;
    idx = 0;
    for (int i = 0; i < MaxReq; i++) begin
      if (onehot[i]) idx = idx | unsigned'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_grant_arbiter_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
interface rr_grant_arbiter_if
  import rr_grant_arbiter_pkg::*;
#(
  parameter int unsigned N = 8
);

  localparam int unsigned IW = $clog2(N);
  localparam int unsigned CW = count_width(N);

  logic [N-1:0]  req;
  logic          release_i;
  logic [N-1:0]  grant;
  logic          grant_vld;
  logic [IW-1:0] grant_idx;
  logic [CW-1:0] req_count;
  logic          timeout;

  modport master (
    output req,
    output release_i,
    input  grant,
    input  grant_vld,
    input  grant_idx,
    input  req_count,
    input  timeout
  );

  modport slave (
    input  req,
    input  release_i,
    output grant,
    output grant_vld,
    output grant_idx,
    output req_count,
    output timeout
  );

endinterface

// File: rtl/rr_grant_arbiter_pick.sv
// Combinational masked round-robin picker: first request at/after ptr, skipping excluded bits.
module rr_grant_arbiter_pick
  import rr_grant_arbiter_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  input  logic [N-1:0]         excl,
  output logic [N-1:0]         onehot,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any
);

  localparam int unsigned IW = $clog2(N);

  logic [N-1:0] w_masked;
  logic [N-1:0] w_rot;
  logic         w_found;
  int unsigned  w_off;
  int unsigned  w_pos;
  logic [N-1:0] w_onehot;

  // Rotate the masked requests so ptr lands on bit 0, then find-first-set and rotate back.
  always_comb begin
    w_masked = req & ~excl;
    w_rot    = N'({w_masked, w_masked} >> ptr);
    w_found  = 1'b0;
    w_off    = 0;
    for (int i = 0; i < N; i++) begin
      if (!w_found && w_rot[i]) begin
        w_found = 1'b1;
        w_off   = unsigned'(i);
      end
    end
    w_pos = w_off + 32'(ptr);
    if (w_pos >= N) w_pos = w_pos - N;
    w_onehot = w_found ? ({{(N-1){1'b0}}, 1'b1} << w_pos) : '0;
  end

  assign onehot = w_onehot;
  assign idx    = IW'(onehot_to_idx(MaxReq'(w_onehot)));
  assign any    = w_found;

endmodule

// File: rtl/rr_grant_arbiter_sva.sv
// Grant-vector and fairness properties, attached to every rr_grant_arbiter instance.
module rr_grant_arbiter_sva #(
  parameter int unsigned N = 8
) (
  input logic         clk,
  input logic         rst_n,
  input logic [N-1:0] req,
  input logic [N-1:0] grant,
  input logic         grant_vld
);

  logic [N-1:0] r_prev_grant;
  // r_seen[j]: requesters granted since j last dropped its request or was granted.
  logic [N-1:0] r_seen [N];
  logic         w_new_grant;
  logic         w_unfair;

  assign w_new_grant = (grant != '0) && (grant != r_prev_grant);

  // Flag a fresh grant to someone already served while another requester kept waiting.
  always_comb begin
    w_unfair = 1'b0;
    for (int j = 0; j < N; j++) begin
      if (w_new_grant && req[j] && !grant[j] && ((r_seen[j] & grant) != '0)) w_unfair = 1'b1;
    end
  end

  // Track who has been served during each requester's continuous wait.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev_grant <= '0;
      for (int j = 0; j < N; j++) r_seen[j] <= '0;
    end else begin
      r_prev_grant <= grant;
      for (int j = 0; j < N; j++) begin
        if (!req[j] || grant[j]) begin
          r_seen[j] <= '0;
        end else if (w_new_grant) begin
          r_seen[j] <= r_seen[j] | grant;
        end
      end
    end
  end

  a_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant));
  a_vld:     assert property (@(posedge clk) disable iff (!rst_n) grant_vld == $onehot(grant));
  a_fair:    assert property (@(posedge clk) disable iff (!rst_n) !w_unfair);

endmodule

bind rr_grant_arbiter rr_grant_arbiter_sva #(
  .N (N)
) u_sva (
  .clk       (clk),
  .rst_n     (rst_n),
  .req       (w_req),
  .grant     (r_grant),
  .grant_vld (w_grant_vld)
);

// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter: registered one-hot grant held until release, grantee drop or timeout.
module rr_grant_arbiter
  import rr_grant_arbiter_pkg::*;
#(
  parameter int unsigned N        = 8,
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  rr_grant_arbiter_if.slave bus
);

  localparam int unsigned IW = $clog2(N);
  localparam int unsigned CW = count_width(N);
  // Counter only has to reach MAX_HOLD-1, the cycle that forces release.
  localparam int unsigned HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HoldLast = HW'(MAX_HOLD - 1);

  arb_state_e    r_state, w_state_nxt;
  logic [IW-1:0] r_ptr, w_ptr_nxt;
  logic [N-1:0]  r_grant, w_grant_nxt;
  logic [IW-1:0] r_idx, w_idx_nxt;
  logic [HW-1:0] r_hold, w_hold_nxt;
  logic          r_timeout, w_timeout_nxt;
  logic [CW-1:0] r_req_count;

  logic [N-1:0]  w_req;
  logic          w_rel_in;
  logic          w_hold_last;
  logic          w_release;
  logic [IW-1:0] w_ptr_adv;
  logic [IW-1:0] w_pick_ptr;
  logic [N-1:0]  w_pick_excl;
  logic [N-1:0]  w_pick_oh;
  logic [IW-1:0] w_pick_idx;
  logic          w_pick_any;
  logic          w_grant_vld;

  assign w_req       = bus.req;
  assign w_rel_in    = bus.release_i;
  assign w_hold_last = (r_hold == HoldLast);
  assign w_release   = (r_state == BUSY) && (w_rel_in || !w_req[r_idx] || w_hold_last);
  assign w_ptr_adv   = (r_idx == IW'(N - 1)) ? '0 : r_idx + IW'(1);

  // On release the search starts just past the grantee and skips it, so a lone
  // requester that keeps asking sees one idle cycle before it is re-granted.
  assign w_pick_ptr  = w_release ? w_ptr_adv : r_ptr;
  assign w_pick_excl = w_release ? r_grant : '0;

  rr_grant_arbiter_pick #(
    .N (N)
  ) u_pick (
    .req    (w_req),
    .ptr    (w_pick_ptr),
    .excl   (w_pick_excl),
    .onehot (w_pick_oh),
    .idx    (w_pick_idx),
    .any    (w_pick_any)
  );

  // Next-state logic for the grant FSM, pointer and hold counter.
  always_comb begin
    w_state_nxt   = r_state;
    w_ptr_nxt     = r_ptr;
    w_grant_nxt   = r_grant;
    w_idx_nxt     = r_idx;
    w_hold_nxt    = r_hold;
    w_timeout_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_pick_any) begin
          w_grant_nxt = w_pick_oh;
          w_idx_nxt   = w_pick_idx;
          w_hold_nxt  = '0;
          w_state_nxt = BUSY;
        end
      end
      BUSY: begin
        // Pulses even when release_i coincides with the forced release.
        w_timeout_nxt = w_hold_last;
        if (w_release) begin
          w_ptr_nxt  = w_ptr_adv;
          w_hold_nxt = '0;
          if (w_pick_any) begin
            w_grant_nxt = w_pick_oh;
            w_idx_nxt   = w_pick_idx;
          end else begin
            w_grant_nxt = '0;
            w_idx_nxt   = '0;
            w_state_nxt = IDLE;
          end
        end else if (!w_hold_last) begin
          w_hold_nxt = r_hold + HW'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_grant_nxt = '0;
        w_idx_nxt   = '0;
        w_hold_nxt  = '0;
      end
    endcase
  end

  // FSM, grant and hold-counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_ptr     <= '0;
      r_grant   <= '0;
      r_idx     <= '0;
      r_hold    <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ptr     <= w_ptr_nxt;
      r_grant   <= w_grant_nxt;
      r_idx     <= w_idx_nxt;
      r_hold    <= w_hold_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  // Registered request population, independent of the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req_count <= '0;
    end else begin
      r_req_count <= CW'($countones(w_req));
    end
  end

  assign w_grant_vld   = |r_grant;
  assign bus.grant     = r_grant;
  assign bus.grant_vld = w_grant_vld;
  assign bus.grant_idx = r_idx;
  assign bus.req_count = r_req_count;
  assign bus.timeout   = r_timeout;

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Scoreboard bench for rr_grant_arbiter (N=8, MAX_HOLD=16).
module tb_rr_grant_arbiter;

  typedef struct packed {
    logic [7:0] grant;
    logic [2:0] idx;
    logic       vld;
    logic [3:0] cnt;
    logic       tmo;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;
  obs_t q_exp[$];
  obs_t exp_o;
  obs_t got_o;

  rr_grant_arbiter_if #(.N(8)) bus ();

  rr_grant_arbiter #(
    .N        (8),
    .MAX_HOLD (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1, "watchdog expired");
  end

  function automatic obs_t mk(input logic [7:0] g, input logic [2:0] i, input logic [3:0] c,
                              input logic t);
    obs_t o;
    o.grant = g;
    o.idx   = i;
    o.vld   = (g != 8'h00);
    o.cnt   = c;
    o.tmo   = t;
    return o;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.grant = bus.grant;
    o.idx   = bus.grant_idx;
    o.vld   = bus.grant_vld;
    o.cnt   = bus.req_count;
    o.tmo   = bus.timeout;
    return o;
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("grant=%b idx=%0d vld=%b cnt=%0d tmo=%b", o.grant, o.idx, o.vld, o.cnt, o.tmo);
  endfunction

  // Drive one cycle of stimulus and land just after the sampling edge.
  task automatic drive_step(input logic [7:0] r, input logic rel);
    @(negedge clk);
    bus.req       = r;
    bus.release_i = rel;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n         = 1'b0;
    bus.req       = 8'h00;
    bus.release_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    bus.req       = 8'h00;
    bus.release_i = 1'b0;
    #2;
    rst_n   = 1'b0;
    bus.req = 8'hFF;
    q_exp.push_back(mk(8'h00, 3'd0, 4'd0, 1'b0));
    @(posedge clk);
    #1;
    exp_o = q_exp.pop_front();
    got_o = sample();
    n_checks++;
    if (got_o !== exp_o) begin
      n_fail++;
      $display("FAIL reset: got %s, expected %s", fmt(got_o), fmt(exp_o));
    end
    @(negedge clk);
    bus.req = 8'h00;
    rst_n   = 1'b1;
  endtask

  task automatic test_basic_pick();
    apply_reset();
    for (int s = 0; s < 2; s++) begin
      q_exp.push_back(mk(8'h04, 3'd2, 4'd2, 1'b0));
      drive_step(8'h24, 1'b0);
      exp_o = q_exp.pop_front();
      got_o = sample();
      n_checks++;
      if (got_o !== exp_o) begin
        n_fail++;
        $display("FAIL basic_pick step %0d: got %s, expected %s", s, fmt(got_o), fmt(exp_o));
      end
    end
  endtask

  // Continues from test_basic_pick: requester 2 holds the grant.
  task automatic test_back_to_back();
    logic [7:0] reqs [4];
    logic       rels [4];
    obs_t       exps [4];
    reqs = '{8'h24, 8'h24, 8'h24, 8'h00};
    rels = '{1'b1, 1'b0, 1'b1, 1'b0};
    exps = '{mk(8'h20, 3'd5, 4'd2, 1'b0), mk(8'h20, 3'd5, 4'd2, 1'b0),
             mk(8'h04, 3'd2, 4'd2, 1'b0), mk(8'h00, 3'd0, 4'd0, 1'b0)};
    for (int s = 0; s < 4; s++) begin
      q_exp.push_back(exps[s]);
      drive_step(reqs[s], rels[s]);
      exp_o = q_exp.pop_front();
      got_o = sample();
      n_checks++;
      if (got_o !== exp_o) begin
        n_fail++;
        $display("FAIL back_to_back step %0d: got %s, expected %s", s, fmt(got_o), fmt(exp_o));
      end
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] g;
    apply_reset();
    for (int s = 0; s < 9; s++) begin
      g = 8'h01 << (s % 8);
      q_exp.push_back(mk(g, 3'(s % 8), 4'd8, 1'b0));
      drive_step(8'hFF, 1'b1);
      exp_o = q_exp.pop_front();
      got_o = sample();
      n_checks++;
      if (got_o !== exp_o) begin
        n_fail++;
        $display("FAIL round_robin step %0d: got %s, expected %s", s, fmt(got_o), fmt(exp_o));
      end
    end
  endtask

  task automatic test_timeout();
    apply_reset();
    for (int s = 0; s < 19; s++) begin
      if (s < 16)       q_exp.push_back(mk(8'h08, 3'd3, 4'd1, 1'b0));
      else if (s == 16) q_exp.push_back(mk(8'h00, 3'd0, 4'd1, 1'b1));
      else              q_exp.push_back(mk(8'h08, 3'd3, 4'd1, 1'b0));
      drive_step(8'h08, 1'b0);
      exp_o = q_exp.pop_front();
      got_o = sample();
      n_checks++;
      if (got_o !== exp_o) begin
        n_fail++;
        $display("FAIL timeout step %0d: got %s, expected %s", s, fmt(got_o), fmt(exp_o));
      end
    end
  endtask

  // release_i on the timeout cycle counts once; the other requester follows without a bubble.
  task automatic test_timeout_with_release();
    apply_reset();
    for (int s = 0; s < 18; s++) begin
      if (s < 16)       q_exp.push_back(mk(8'h02, 3'd1, 4'd2, 1'b0));
      else if (s == 16) q_exp.push_back(mk(8'h08, 3'd3, 4'd2, 1'b1));
      else              q_exp.push_back(mk(8'h08, 3'd3, 4'd2, 1'b0));
      drive_step(8'h0A, (s == 16));
      exp_o = q_exp.pop_front();
      got_o = sample();
      n_checks++;
      if (got_o !== exp_o) begin
        n_fail++;
        $display("FAIL timeout_release step %0d: got %s, expected %s", s, fmt(got_o),
                 fmt(exp_o));
      end
    end
  endtask

  task automatic test_grantee_drop();
    logic [7:0] reqs [4];
    logic       rels [4];
    obs_t       exps [4];
    apply_reset();
    reqs = '{8'h81, 8'h80, 8'h81, 8'h81};
    rels = '{1'b0, 1'b0, 1'b0, 1'b1};
    exps = '{mk(8'h01, 3'd0, 4'd2, 1'b0), mk(8'h80, 3'd7, 4'd1, 1'b0),
             mk(8'h80, 3'd7, 4'd2, 1'b0), mk(8'h01, 3'd0, 4'd2, 1'b0)};
    for (int s = 0; s < 4; s++) begin
      q_exp.push_back(exps[s]);
      drive_step(reqs[s], rels[s]);
      exp_o = q_exp.pop_front();
      got_o = sample();
      n_checks++;
      if (got_o !== exp_o) begin
        n_fail++;
        $display("FAIL grantee_drop step %0d: got %s, expected %s", s, fmt(got_o), fmt(exp_o));
      end
      n_checks++;
      if (!$onehot0(bus.grant)) begin
        n_fail++;
        $display("FAIL grantee_drop onehot0 step %0d: got grant=%b, required at most one bit",
                 s, bus.grant);
      end
    end
  endtask

  task automatic test_reset_mid_grant();
    apply_reset();
    q_exp.push_back(mk(8'h04, 3'd2, 4'd2, 1'b0));
    drive_step(8'h24, 1'b0);
    exp_o = q_exp.pop_front();
    got_o = sample();
    n_checks++;
    if (got_o !== exp_o) begin
      n_fail++;
      $display("FAIL reset_mid_grant pre: got %s, expected %s", fmt(got_o), fmt(exp_o));
    end
    // Reset asserted between clock edges must clear the grant immediately.
    @(negedge clk);
    rst_n = 1'b0;
    q_exp.push_back(mk(8'h00, 3'd0, 4'd0, 1'b0));
    #1;
    exp_o = q_exp.pop_front();
    got_o = sample();
    n_checks++;
    if (got_o !== exp_o) begin
      n_fail++;
      $display("FAIL reset_mid_grant async: got %s, expected %s", fmt(got_o), fmt(exp_o));
    end
    bus.req = 8'hC0;
    @(negedge clk);
    rst_n = 1'b1;
    q_exp.push_back(mk(8'h40, 3'd6, 4'd2, 1'b0));
    @(posedge clk);
    #1;
    exp_o = q_exp.pop_front();
    got_o = sample();
    n_checks++;
    if (got_o !== exp_o) begin
      n_fail++;
      $display("FAIL reset_mid_grant post: got %s, expected %s", fmt(got_o), fmt(exp_o));
    end
  endtask

  initial begin
    bus.req       = 8'h00;
    bus.release_i = 1'b0;
    test_reset();
    test_basic_pick();
    test_back_to_back();
    test_round_robin();
    test_timeout();
    test_timeout_with_release();
    test_grantee_drop();
    test_reset_mid_grant();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
